onchip_mem_pipe: RTL and testbench

ONCHIP_MEM_PIPE -- requirements
Module: onchip_mem_pipe

---
 rtl/onchip_mem_pkg.sv | 25 ++
 rtl/onchip_mem_ram.sv | 30 +++
 rtl/onchip_mem_pipe.sv | 173 +++++++++++++++++
 tb/tb_onchip_mem_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared types, defaults and the parity helper for the onchip_mem_pipe block.
// Defining ONCHIP_MEM_PARITY_EN widens each stored byte lane by one even-parity bit.
package onchip_mem_pkg;

    typedef enum logic [0:0] {
        INIT_CLR = 1'b0,
        READY    = 1'b1
    } state_t;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_DEPTH          = 23040;
    localparam int DEF_READ_LATENCY   = 1;
    localparam int DEF_CLEAR_ON_RESET = 0;

`ifdef ONCHIP_MEM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/onchip_mem_ram.sv
// Inferred single-port RAM with per-lane write enables and a registered read port.
// Lane width comes from the package so the parity bit travels with each byte.
module onchip_mem_ram
    import onchip_mem_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic                         re,
    input  logic [AW-1:0]                addr,
    input  logic [LANES-1:0]             be,
    input  logic [LANES-1:0][LANE_W-1:0] wdata,
    output logic [LANES-1:0][LANE_W-1:0] rdata
);

    logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[addr][i] <= wdata[i];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/onchip_mem_pipe.sv
// Avalon-style on-chip memory slave with clken stall, optional zero-fill and a 1/2-stage read pipe.
// Defining ONCHIP_MEM_PARITY_EN enables per-byte parity storage and the sticky parity_err flag.
module onchip_mem_pipe
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET,
    localparam int AW            = $clog2(DEPTH),
    localparam int BE_W          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [AW-1:0]     address,
    input  logic [BE_W-1:0]   byteenable,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              clken,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              range_err,
    output logic              parity_err,
    output state_t            state
);

    logic [AW-1:0] clr_cnt;
    logic          in_range;
    logic          accept;
    logic          acc_rd;
    logic          acc_wr;
    logic          clr_we;

    logic                         ram_we;
    logic                         ram_re;
    logic [AW-1:0]                ram_addr;
    logic [BE_W-1:0]              ram_be;
    logic [BE_W-1:0][LANE_W-1:0]  ram_wdata;
    logic [BE_W-1:0][LANE_W-1:0]  ram_rdata;

    logic                         s1_valid;
    logic                         s1_oob;
    logic                         out_valid;
    logic                         out_oob;
    logic [BE_W-1:0][LANE_W-1:0]  out_word;

    // reset_n gates acceptance so nothing reaches the RAM while reset is held.
    assign in_range = (32'(address) < 32'(DEPTH));
    assign accept   = reset_n && (state == READY) && chipselect && clken && (read || write);
    assign acc_wr   = accept && write;
    assign acc_rd   = accept && read && !write;
    assign clr_we   = reset_n && (state == INIT_CLR) && clken;

    assign waitrequest = !reset_n || (state != READY) || !clken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? INIT_CLR : READY;
            clr_cnt <= '0;
        end else if (clken && state == INIT_CLR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == AW'(DEPTH - 1)) state <= READY;
        end
    end

    always_comb begin
        ram_we   = clr_we || (acc_wr && in_range);
        ram_re   = acc_rd && in_range;
        ram_addr = address;
        ram_be   = byteenable;
        for (int i = 0; i < BE_W; i++) begin
`ifdef ONCHIP_MEM_PARITY_EN
            ram_wdata[i] = {even_parity(writedata[i*8 +: 8]), writedata[i*8 +: 8]};
`else
            ram_wdata[i] = writedata[i*8 +: 8];
`endif
        end
        if (state == INIT_CLR) begin
            ram_addr  = clr_cnt;
            ram_be    = '1;
            ram_wdata = '0;
        end
    end

    onchip_mem_ram #(
        .LANES (BE_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Out-of-range reads still flow down the pipe so their readdatavalid keeps normal timing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_oob   <= 1'b0;
        end else if (clken) begin
            s1_valid <= acc_rd;
            s1_oob   <= !in_range;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                        s2_valid;
            logic                        s2_oob;
            logic [BE_W-1:0][LANE_W-1:0] s2_word;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s2_valid <= 1'b0;
                    s2_oob   <= 1'b0;
                    s2_word  <= '0;
                end else if (clken) begin
                    s2_valid <= s1_valid;
                    s2_oob   <= s1_oob;
                    s2_word  <= ram_rdata;
                end
            end

            assign out_valid = s2_valid;
            assign out_oob   = s2_oob;
            assign out_word  = s2_word;
        end else begin : g_lat1
            assign out_valid = s1_valid;
            assign out_oob   = s1_oob;
            assign out_word  = ram_rdata;
        end
    endgenerate

    // A stalled result stays hidden until clken returns, then shows for one cycle.
    assign readdatavalid = out_valid && clken;

    always_comb begin
        readdata = '0;
        if (readdatavalid && !out_oob) begin
            for (int i = 0; i < BE_W; i++) readdata[i*8 +: 8] = out_word[i][7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) range_err <= 1'b0;
        else          range_err <= accept && !in_range;
    end

`ifdef ONCHIP_MEM_PARITY_EN
    logic par_bad;

    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            if (out_word[i][8] != even_parity(out_word[i][7:0])) par_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                    parity_err <= 1'b0;
        else if (readdatavalid && !out_oob && par_bad)   parity_err <= 1'b1;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_mem_pipe.sv
// Directed plus short random bench driving two onchip_mem_pipe instances from shared stimulus:
// A = defaults (latency 1, 23040 words), B = latency 2, 16 words, zero-fill after reset.
module tb_onchip_mem_pipe;
    import onchip_mem_pkg::*;

    localparam int DEPTH_A = 23040;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        cs_a       = 1'b0;
    logic        cs_b       = 1'b0;
    logic        read       = 1'b0;
    logic        write      = 1'b0;
    logic        clken      = 1'b1;
    logic [14:0] address    = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] writedata  = '0;

    logic        waitrequest_a, waitrequest_b;
    logic [31:0] readdata_a, readdata_b;
    logic        rdv_a, rdv_b;
    logic        range_err_a, range_err_b;
    logic        parity_err_a, parity_err_b;
    state_t      state_a, state_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    logic [31:0] model_a [int];
    logic [31:0] model_b [16];

    always #5 clk = ~clk;

    onchip_mem_pipe dut_a (
        .clk(clk), .reset_n(reset_n), .chipselect(cs_a), .address(address),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .waitrequest(waitrequest_a), .readdata(readdata_a),
        .readdatavalid(rdv_a), .range_err(range_err_a), .parity_err(parity_err_a),
        .state(state_a)
    );

    onchip_mem_pipe #(.DATA_W(32), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .chipselect(cs_b), .address(address[3:0]),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .waitrequest(waitrequest_b), .readdata(readdata_b),
        .readdatavalid(rdv_b), .range_err(range_err_b), .parity_err(parity_err_b),
        .state(state_b)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int i = 0; i < 4; i++) if (be[i]) m[i*8 +: 8] = d[i*8 +: 8];
        return m;
    endfunction

    // Scoreboard: every readdatavalid pops the oldest expectation; idle cycles must show zero data.
    always @(negedge clk) begin
        if (rdv_a) begin
            if (exp_q_a.size() == 0) check_bit("unexpected_rdv_a", rdv_a, 1'b0);
            else                     check_word("readdata_a", readdata_a, exp_q_a.pop_front());
        end else begin
            check_word("idle_readdata_a", readdata_a, 32'h0);
        end
        if (rdv_b) begin
            if (exp_q_b.size() == 0) check_bit("unexpected_rdv_b", rdv_b, 1'b0);
            else                     check_word("readdata_b", readdata_b, exp_q_b.pop_front());
        end else begin
            check_word("idle_readdata_b", readdata_b, 32'h0);
        end
    end

    task automatic accept_model(input int sel_a, input int sel_b, input int r, input int w,
                                input int a, input int be, input logic [31:0] d);
        if (w != 0) begin
            if (sel_a != 0 && a < DEPTH_A)
                model_a[a] = merge(model_a.exists(a) ? model_a[a] : 32'h0, d, 4'(be));
            if (sel_b != 0)
                model_b[a % 16] = merge(model_b[a % 16], d, 4'(be));
        end else if (r != 0) begin
            if (sel_a != 0) exp_q_a.push_back((a < DEPTH_A) ? model_a[a] : 32'h0);
            if (sel_b != 0) exp_q_b.push_back(model_b[a % 16]);
        end
    endtask

    // Drives one request and holds it until every selected slave accepts it; returns at #1 after
    // the accepting edge with the request still applied.
    task automatic req(input int sel_a, input int sel_b, input int r, input int w, input int a,
                       input int be, input logic [31:0] d, input int stall);
        bit done;
        done       = 1'b0;
        cs_a       = (sel_a != 0);
        cs_b       = (sel_b != 0);
        read       = (r != 0);
        write      = (w != 0);
        address    = 15'(a);
        byteenable = 4'(be);
        writedata  = d;
        if (stall != 0) begin
            clken = 1'b0;
            @(negedge clk);
            if (sel_a != 0) check_bit("stall_wait_a", waitrequest_a, 1'b1);
            if (sel_b != 0) check_bit("stall_wait_b", waitrequest_b, 1'b1);
            check_bit("stall_rdv_a", rdv_a, 1'b0);
            check_bit("stall_rdv_b", rdv_b, 1'b0);
            @(posedge clk); #1;
            clken = 1'b1;
        end
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if ((sel_a == 0 || !waitrequest_a) && (sel_b == 0 || !waitrequest_b)) begin
                accept_model(sel_a, sel_b, r, w, a, be, d);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check_word("req_timeout", {30'h0, waitrequest_a, waitrequest_b}, 32'h0);
    endtask

    task automatic idle(input int n);
        cs_a  = 1'b0;
        cs_b  = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_checks();
        @(negedge clk);
        check_word("rst_readdata_a", readdata_a, 32'h0);
        check_word("rst_readdata_b", readdata_b, 32'h0);
        check_bit("rst_rdv_a", rdv_a, 1'b0);
        check_bit("rst_rdv_b", rdv_b, 1'b0);
        check_bit("rst_range_err_a", range_err_a, 1'b0);
        check_bit("rst_parity_err_a", parity_err_a, 1'b0);
        check_bit("rst_parity_err_b", parity_err_b, 1'b0);
        check_bit("rst_wait_a", waitrequest_a, 1'b1);
        check_bit("rst_wait_b", waitrequest_b, 1'b1);
        @(posedge clk); #1;
    endtask

    // Releases reset and counts the cycles B stays busy zero-filling.
    task automatic release_and_count_clear();
        int  n;
        bit  busy;
        n = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) model_b[i] = 32'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            busy = waitrequest_b;
            if (i == 0) begin
                check_bit("ready_wait_a", waitrequest_a, 1'b0);
                check_bit("state_a_ready", state_a == READY, 1'b1);
                check_bit("state_b_clr", state_b == INIT_CLR, 1'b1);
            end
            @(posedge clk); #1;
            if (!busy) break;
            n++;
        end
        check_word("clear_cycles_b", n, 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, op, be;

        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_checks();
        release_and_count_clear();

        // Zero-filled B reads back zero everywhere.
        for (int i = 0; i < 16; i++) req(0, 1, 1, 0, i, 0, 32'h0, 0);
        idle(4);

        // Latency: A answers one cycle after acceptance, B two.
        req(1, 1, 0, 1, 5, 15, 32'hDEADBEEF, 0);
        req(1, 1, 1, 0, 5, 0, 32'h0, 0);
        idle(0);
        @(negedge clk);
        check_bit("lat1_rdv_a", rdv_a, 1'b1);
        check_bit("lat2_rdv_b_early", rdv_b, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("lat2_rdv_b", rdv_b, 1'b1);
        check_bit("lat1_rdv_a_once", rdv_a, 1'b0);
        idle(2);

        // Partial write followed immediately by a read of the same word.
        req(1, 1, 0, 1, 7, 15, 32'h11223344, 0);
        req(1, 1, 0, 1, 7, 3, 32'hAABBCCDD, 0);
        req(1, 1, 1, 0, 7, 0, 32'h0, 0);
        idle(4);

        // Back-to-back reads with a clken stall on the second.
        for (int i = 0; i < 4; i++) req(1, 1, 0, 1, i, 15, $urandom, 0);
        req(1, 1, 1, 0, 0, 0, 32'h0, 0);
        req(1, 1, 1, 0, 1, 0, 32'h0, 1);
        req(1, 1, 1, 0, 2, 0, 32'h0, 0);
        req(1, 1, 1, 0, 3, 0, 32'h0, 0);
        idle(5);

        // Simultaneous read and write performs only the write.
        req(1, 1, 1, 1, 9, 15, 32'hCAFEF00D, 0);
        idle(4);
        req(1, 1, 1, 0, 9, 0, 32'h0, 0);
        idle(4);

        // Range handling on A.
        req(1, 0, 1, 0, DEPTH_A, 0, 32'h0, 0);
        idle(0);
        @(negedge clk);
        check_bit("range_err_read", range_err_a, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("range_err_pulse_end", range_err_a, 1'b0);
        @(posedge clk); #1;
        req(1, 0, 0, 1, DEPTH_A + 1, 15, 32'h12345678, 0);
        idle(0);
        @(negedge clk);
        check_bit("range_err_write", range_err_a, 1'b1);
        @(posedge clk); #1;
        req(1, 0, 0, 1, DEPTH_A - 1, 15, 32'h0BADCAFE, 0);
        req(1, 0, 1, 0, DEPTH_A - 1, 0, 32'h0, 0);
        idle(0);
        @(negedge clk);
        check_bit("range_err_last_word", range_err_a, 1'b0);
        @(posedge clk); #1;
        req(1, 0, 1, 0, 5, 0, 32'h0, 0);
        idle(4);

        // Random mix on addresses 8..15 in both instances.
        for (int i = 8; i < 16; i++) req(1, 1, 0, 1, i, 15, $urandom, 0);
        for (int i = 0; i < 40; i++) begin
            a  = $urandom_range(8, 15);
            op = $urandom_range(0, 2);
            be = $urandom_range(1, 15);
            req(1, 1, (op != 0) ? 1 : 0, (op != 1) ? 1 : 0, a, be, $urandom,
                ($urandom_range(0, 4) == 0) ? 1 : 0);
        end
        idle(5);

`ifdef ONCHIP_MEM_PARITY_EN
        dut_a.u_ram.mem[3][0][0] = ~dut_a.u_ram.mem[3][0][0];
        model_a[3] = model_a[3] ^ 32'h1;
        req(1, 0, 1, 0, 3, 0, 32'h0, 0);
        idle(1);
        @(negedge clk);
        check_bit("parity_err_set", parity_err_a, 1'b1);
        @(posedge clk); #1;
        idle(4);
        @(negedge clk);
        check_bit("parity_err_sticky", parity_err_a, 1'b1);
        @(posedge clk); #1;
`endif

        // Reset with reads in flight: nothing may come out, memory of A survives.
        req(1, 1, 1, 0, 5, 0, 32'h0, 0);
        reset_n = 1'b0;
        exp_q_a.delete();
        exp_q_b.delete();
        idle(0);
        reset_checks();
        reset_checks();
        release_and_count_clear();
        req(1, 0, 1, 0, 5, 0, 32'h0, 0);
        req(0, 1, 1, 0, 7, 0, 32'h0, 0);
        idle(6);

        check_word("exp_q_a_drained", exp_q_a.size(), 32'h0);
        check_word("exp_q_b_drained", exp_q_b.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
